pi_series_sched: RTL
====================

// Module: pi_series_sched
// PURPOSE
//  Sequencer for the Leibniz pi datapath: runs n_pairs (+1/a - 1/(a+2)) term pairs through
//  ONE shared iterative restoring divider instead of parallel combinational dividers.
//  Accumulates pi in fixed point (M = 2^(4*Q+2), i.e. 4*Q fraction bits).
//  Sits in top between SWI (start/abort/count) and lcd_a/lcd_b/LED (pi, progress, status).
// PARAMETERS
//  W   48  datapath width: quotient, accumulator, a, divider remainder (needs W >= 4*Q+3)
//  Q   11  hex fraction digits; dividend M = 1 << (4*Q+2)
//  CW  24  width of pair counter and n_pairs
// PORTS
//  clk_2     in   1   system clock, all state on posedge
//  reset     in   1   asynchronous, active-low (0 = reset)
//  start     in   1   level/pulse; sampled only in IDLE
//  abort     in   1   stops a running computation
//  n_pairs   in   CW  term pairs to compute, latched at start
//  busy      out  1   1 in DIV_POS, DIV_NEG, ACC
//  done      out  1   one-cycle pulse, normal completion only
//  pi        out  W   accumulator; 4*Q fraction bits
//  pairs     out  CW  pairs accumulated so far
//  st        out  2   state code IDLE=0 DIV_POS=1 DIV_NEG=2 ACC=3; DONE also shows 0
// BEHAVIOUR
//  Reset (reset=0, async): st=IDLE, busy=0, done=0, pi=0, pairs=0, a=1, divider cleared.
//  IDLE: start=1 & abort=0 -> latch n_pairs; pi<=0, pairs<=0, a<=1.
//   If latched n_pairs==0 -> DONE next cycle; else -> DIV_POS.
//   start & abort in the same IDLE cycle: abort wins, stay IDLE, nothing cleared.
//  DIV_POS: computes qpos = M / a; exactly W cycles, one quotient bit per cycle, MSB first;
//   divider loads on entry. After the W-th cycle -> DIV_NEG.
//  DIV_NEG: computes qneg = M / (a+2); exactly W cycles -> ACC.
//  ACC (1 cycle): pi <= pi + qpos - qneg (mod 2^W); a <= a + 4; pairs <= pairs + 1.
//   -> DONE if pairs+1 == n_pairs OR qpos == qneg (term underflow); else -> DIV_POS.
//  DONE (1 cycle): done=1, busy=0 -> IDLE. pi and pairs hold until the next accepted start.
//  Latency: start accepted in cycle t -> done=1 in cycle t+1+N*(2W+1), N = pairs executed.
//   n_pairs==0 -> done in cycle t+1.
//  Division semantics: truncating unsigned; dividend width W+1; divisor is always odd and
//   nonzero. a, a+2 computed in W bits; wrap cannot occur before qpos==qneg stops the run.
//  abort=1 in DIV_POS/DIV_NEG/ACC -> IDLE next cycle. No done pulse.
//   pi/pairs keep the last completed ACC value; a partial divide is discarded.
//  start while busy or in DONE: ignored; no re-latch of n_pairs.
//  n_pairs input changes while busy: no effect.
//  Reset mid-operation: immediate return to reset values. No done pulse.
//  Only one divide is in flight at a time; qpos is held in a register across DIV_NEG.
// TESTING
//  1: reset=0 then 1, idle -> busy=0, done=0, pi=0, pairs=0, st=0 for 10 cycles.
//  2: n_pairs=1, start pulse in cycle t -> pi=0x2AAAAAAAAAAB, pairs=1, done only in cycle t+98.
//  3: n_pairs=2 -> pi=0x2E52E52E52E5 (~2.895), done in cycle t+195; busy=1 in t+1..t+194.
//  4: n_pairs=0 -> done in cycle t+1, pi=0, busy never 1.
//  5: n_pairs=5; abort after the 2nd ACC, mid DIV_POS ->
//     IDLE next cycle, pi=0x2E52E52E52E5, pairs=2, no done.
//  6: start re-pulsed while busy, start+abort together in IDLE, and reset=0 mid DIV_NEG
//     -> ignored / stay IDLE / all outputs at reset values.

Source files
------------

// File: rtl/pi_series_sched.sv
// Leibniz pi sequencer: feeds +1/a - 1/(a+2) term pairs through one shared
// iterative restoring divider and accumulates pi with 4*Q fraction bits.
module pi_series_sched #(
    parameter int W  = 48,
    parameter int Q  = 11,
    parameter int CW = 24
) (
    input  logic          clk_2,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic [CW-1:0] n_pairs,
    output logic          busy,
    output logic          done,
    output logic [W-1:0]  pi,
    output logic [CW-1:0] pairs,
    output logic [1:0]    st
);
    localparam int CNTW = $clog2(W);
    localparam logic [W-1:0]    M_DIV    = W'(1) << (4*Q + 2);
    localparam logic [W-1:0]    ONE      = W'(1);
    localparam logic [W-1:0]    TWO      = W'(2);
    localparam logic [W-1:0]    FOUR     = W'(4);
    localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(W - 1);
    localparam logic [CW-1:0]   PAIR_ONE = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DIV_POS,
        S_DIV_NEG,
        S_ACC,
        S_DONE
    } state_t;

    state_t          state, state_next;
    logic [CW-1:0]   n_lat;
    logic [W-1:0]    a;
    logic [W-1:0]    qpos;
    logic [W-1:0]    rem;
    logic [W-1:0]    dq;
    logic [CNTW-1:0] cnt;

    logic [W-1:0]    divisor, diff, rem_step, q_step, acc_sum;
    logic [W:0]      trial;
    logic            fits, last_bit, run_end;

    // dq shifts dividend bits out at the top and quotient bits in at the bottom
    always_comb begin
        divisor  = (state == S_DIV_NEG) ? a + TWO : a;
        trial    = {rem, dq[W-1]};
        fits     = trial >= {1'b0, divisor};
        diff     = trial[W-1:0] - divisor;
        rem_step = fits ? diff : trial[W-1:0];
        q_step   = {dq[W-2:0], fits};
        last_bit = (cnt == CNT_LAST);
        acc_sum  = pi + qpos - dq;
        run_end  = ((pairs + PAIR_ONE) == n_lat) || (qpos == dq);
    end

    always_ff @(posedge clk_2 or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        st         = 2'd0;
        case (state)
            S_IDLE: begin
                if (start && !abort) begin
                    state_next = (n_pairs == '0) ? S_DONE : S_DIV_POS;
                end
            end
            S_DIV_POS: begin
                busy = 1'b1;
                st   = 2'd1;
                if (abort) begin
                    state_next = S_IDLE;
                end else if (last_bit) begin
                    state_next = S_DIV_NEG;
                end
            end
            S_DIV_NEG: begin
                busy = 1'b1;
                st   = 2'd2;
                if (abort) begin
                    state_next = S_IDLE;
                end else if (last_bit) begin
                    state_next = S_ACC;
                end
            end
            S_ACC: begin
                busy = 1'b1;
                st   = 2'd3;
                if (abort) begin
                    state_next = S_IDLE;
                end else begin
                    state_next = run_end ? S_DONE : S_DIV_POS;
                end
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // The divider is reloaded whenever a new quotient is about to start; in ACC dq holds qneg
    always_ff @(posedge clk_2 or negedge reset) begin
        if (!reset) begin
            n_lat <= '0;
            a     <= ONE;
            qpos  <= '0;
            rem   <= '0;
            dq    <= '0;
            cnt   <= '0;
            pi    <= '0;
            pairs <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && !abort) begin
                        n_lat <= n_pairs;
                        pi    <= '0;
                        pairs <= '0;
                        a     <= ONE;
                        rem   <= '0;
                        dq    <= M_DIV;
                        cnt   <= '0;
                    end
                end
                S_DIV_POS, S_DIV_NEG: begin
                    if (!abort) begin
                        if (state == S_DIV_POS && last_bit) begin
                            qpos <= q_step;
                            rem  <= '0;
                            dq   <= M_DIV;
                            cnt  <= '0;
                        end else begin
                            rem <= rem_step;
                            dq  <= q_step;
                            cnt <= last_bit ? '0 : cnt + CNT_ONE;
                        end
                    end
                end
                S_ACC: begin
                    if (!abort) begin
                        pi    <= acc_sum;
                        a     <= a + FOUR;
                        pairs <= pairs + PAIR_ONE;
                        rem   <= '0;
                        dq    <= M_DIV;
                        cnt   <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
